// File: rtl/tage_update_unit.sv
// TAGE write-side update unit: provider counter/useful update, allocation
// on mispredict, useful decay on failed allocation, periodic useful flush.
module tage_update_unit #(
    parameter int IDX_W     = 10,
    parameter int TAG_W     = 8,
    parameter int CTR_W     = 3,
    parameter int U_W       = 2,
    parameter int URST_LOG2 = 18
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cm_valid,
    input  logic                 cm_taken,
    input  logic                 cm_mispred,
    input  logic                 cm_prov_valid,
    input  logic [1:0]           cm_provider,
    input  logic                 cm_alt_pred,
    input  logic [4*CTR_W-1:0]   cm_ctr,
    input  logic [4*U_W-1:0]     cm_useful,
    input  logic [4*IDX_W-1:0]   cm_index,
    input  logic [4*TAG_W-1:0]   cm_tag,
    output logic [3:0]           upd_en,
    output logic [4*IDX_W-1:0]   upd_index,
    output logic [4*CTR_W-1:0]   upd_ctr,
    output logic [4*U_W-1:0]     upd_useful,
    output logic [4*TAG_W-1:0]   upd_tag,
    output logic [3:0]           upd_tag_we,
    output logic                 alloc_fail,
    output logic                 flush_ubits_hi,
    output logic                 flush_ubits_lo
);

    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [U_W-1:0]   U_MAX   = '1;

    logic [7:0]           lfsr;
    logic                 prob;
    logic [URST_LOG2-1:0] cm_cnt;
    logic                 phase;

    logic [3:0]           n_en;
    logic [3:0]           n_twe;
    logic [4*IDX_W-1:0]   n_index;
    logic [4*CTR_W-1:0]   n_ctr;
    logic [4*U_W-1:0]     n_useful;
    logic [4*TAG_W-1:0]   n_tag;
    logic                 n_fail;

    logic                 alloc_ok;
    logic [3:0]           cand;
    logic [3:0]           free;
    logic [1:0]           c0;
    logic [1:0]           c1;
    logic [1:0]           pick;
    logic                 have0;
    logic                 have1;
    logic [CTR_W-1:0]     rc;
    logic [U_W-1:0]       ru;

    assign prob = lfsr < 8'd170;

    always_comb begin
        n_en     = '0;
        n_twe    = '0;
        n_index  = '0;
        n_ctr    = '0;
        n_useful = '0;
        n_tag    = '0;
        n_fail   = 1'b0;
        cand     = '0;
        free     = '0;
        c0       = '0;
        c1       = '0;
        have0    = 1'b0;
        have1    = 1'b0;
        rc       = '0;
        ru       = '0;
        alloc_ok = cm_mispred && !(cm_prov_valid && cm_provider == 2'd3);

        for (int j = 0; j < 4; j++) begin
            rc = cm_ctr[j*CTR_W +: CTR_W];
            ru = cm_useful[j*U_W +: U_W];
            if (cm_prov_valid && cm_provider == 2'(j)) begin
                n_en[j] = 1'b1;
                n_index[j*IDX_W +: IDX_W] = cm_index[j*IDX_W +: IDX_W];
                if (cm_taken)
                    n_ctr[j*CTR_W +: CTR_W] = (rc == CTR_MAX) ? rc : rc + 1'b1;
                else
                    n_ctr[j*CTR_W +: CTR_W] = (rc == '0) ? rc : rc - 1'b1;
                // useful only moves when provider and alternate disagree
                if (rc[CTR_W-1] != cm_alt_pred) begin
                    if (rc[CTR_W-1] == cm_taken)
                        ru = (ru == U_MAX) ? ru : ru + 1'b1;
                    else
                        ru = (ru == '0) ? ru : ru - 1'b1;
                end
                n_useful[j*U_W +: U_W] = ru;
            end
            cand[j] = alloc_ok && (!cm_prov_valid || 2'(j) > cm_provider);
            free[j] = cand[j] && (cm_useful[j*U_W +: U_W] == '0);
            if (free[j] && !have0) begin
                c0    = 2'(j);
                have0 = 1'b1;
            end else if (free[j] && !have1) begin
                c1    = 2'(j);
                have1 = 1'b1;
            end
        end

        pick = (have1 && !prob) ? c1 : c0;

        for (int j = 0; j < 4; j++) begin
            rc = cm_ctr[j*CTR_W +: CTR_W];
            ru = cm_useful[j*U_W +: U_W];
            if (have0 && pick == 2'(j)) begin
                n_en[j]  = 1'b1;
                n_twe[j] = 1'b1;
                n_index[j*IDX_W +: IDX_W] = cm_index[j*IDX_W +: IDX_W];
                n_tag[j*TAG_W +: TAG_W]   = cm_tag[j*TAG_W +: TAG_W];
                n_ctr[j*CTR_W +: CTR_W]   = cm_taken ? CTR_WT : CTR_WNT;
                n_useful[j*U_W +: U_W]    = '0;
            end else if (!have0 && cand[j]) begin
                n_en[j] = 1'b1;
                n_fail  = 1'b1;
                n_index[j*IDX_W +: IDX_W] = cm_index[j*IDX_W +: IDX_W];
                n_ctr[j*CTR_W +: CTR_W]   = rc;
                n_useful[j*U_W +: U_W]    = (ru == '0) ? ru : ru - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr           <= 8'hFF;
            cm_cnt         <= '0;
            phase          <= 1'b0;
            upd_en         <= '0;
            upd_index      <= '0;
            upd_ctr        <= '0;
            upd_useful     <= '0;
            upd_tag        <= '0;
            upd_tag_we     <= '0;
            alloc_fail     <= 1'b0;
            flush_ubits_hi <= 1'b0;
            flush_ubits_lo <= 1'b0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (cm_valid) begin
                upd_en     <= n_en;
                upd_index  <= n_index;
                upd_ctr    <= n_ctr;
                upd_useful <= n_useful;
                upd_tag    <= n_tag;
                upd_tag_we <= n_twe;
                alloc_fail <= n_fail;
                cm_cnt     <= cm_cnt + 1'b1;
                if (cm_cnt == '1) begin
                    flush_ubits_hi <= !phase;
                    flush_ubits_lo <= phase;
                    phase          <= !phase;
                end else begin
                    flush_ubits_hi <= 1'b0;
                    flush_ubits_lo <= 1'b0;
                end
            end else begin
                upd_en         <= '0;
                upd_index      <= '0;
                upd_ctr        <= '0;
                upd_useful     <= '0;
                upd_tag        <= '0;
                upd_tag_we     <= '0;
                alloc_fail     <= 1'b0;
                flush_ubits_hi <= 1'b0;
                flush_ubits_lo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tage_update_unit.sv
// Scoreboard bench for tage_update_unit: reference model queues expected
// write requests per commit, compared one cycle later.
module tb_tage_update_unit;

    localparam int IDX_W = 10;
    localparam int TAG_W = 8;
    localparam int CTR_W = 3;
    localparam int U_W   = 2;
    localparam int URST  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                cm_valid;
    logic                cm_taken;
    logic                cm_mispred;
    logic                cm_prov_valid;
    logic [1:0]          cm_provider;
    logic                cm_alt_pred;
    logic [4*CTR_W-1:0]  cm_ctr;
    logic [4*U_W-1:0]    cm_useful;
    logic [4*IDX_W-1:0]  cm_index;
    logic [4*TAG_W-1:0]  cm_tag;
    logic [3:0]          upd_en;
    logic [4*IDX_W-1:0]  upd_index;
    logic [4*CTR_W-1:0]  upd_ctr;
    logic [4*U_W-1:0]    upd_useful;
    logic [4*TAG_W-1:0]  upd_tag;
    logic [3:0]          upd_tag_we;
    logic                alloc_fail;
    logic                flush_ubits_hi;
    logic                flush_ubits_lo;

    always #5 clk = ~clk;

    tage_update_unit #(
        .IDX_W(IDX_W), .TAG_W(TAG_W), .CTR_W(CTR_W),
        .U_W(U_W), .URST_LOG2(URST)
    ) dut (
        .clk(clk), .rst(rst),
        .cm_valid(cm_valid), .cm_taken(cm_taken),
        .cm_mispred(cm_mispred), .cm_prov_valid(cm_prov_valid),
        .cm_provider(cm_provider), .cm_alt_pred(cm_alt_pred),
        .cm_ctr(cm_ctr), .cm_useful(cm_useful),
        .cm_index(cm_index), .cm_tag(cm_tag),
        .upd_en(upd_en), .upd_index(upd_index),
        .upd_ctr(upd_ctr), .upd_useful(upd_useful),
        .upd_tag(upd_tag), .upd_tag_we(upd_tag_we),
        .alloc_fail(alloc_fail),
        .flush_ubits_hi(flush_ubits_hi),
        .flush_ubits_lo(flush_ubits_lo)
    );

    typedef struct packed {
        logic [3:0]  en;
        logic [39:0] idx;
        logic [11:0] ctr;
        logic [7:0]  u;
        logic [31:0] tag;
        logic [3:0]  twe;
        logic        fail;
        logic        fhi;
        logic        flo;
    } out_t;

    out_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  m_lfsr = 8'hFF;
    int          m_cnt = 0;
    logic        m_phase = 1'b0;
    int          low = 0;

    localparam logic [39:0] IDX = {10'd400, 10'd300, 10'd200, 10'd100};
    localparam logic [31:0] TAG = 32'hD4C3B2A1;

    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic out_t model(
        input logic r, v, tk, mp, pv, input logic [1:0] pr,
        input logic alt, input logic [11:0] ctr, input logic [7:0] u,
        input logic [39:0] idx, input logic [31:0] tag,
        input logic [7:0] lf);
        out_t o = '0;
        int p;
        int f[$];
        int pick;
        logic [2:0] c;
        logic [1:0] uu;
        if (r || !v) return o;
        p = int'(pr);
        if (pv) begin
            c  = ctr[p*3 +: 3];
            uu = u[p*2 +: 2];
            o.en[p] = 1'b1;
            o.idx[p*10 +: 10] = idx[p*10 +: 10];
            if (tk) o.ctr[p*3 +: 3] = (c == 3'd7) ? 3'd7 : c + 3'd1;
            else    o.ctr[p*3 +: 3] = (c == 3'd0) ? 3'd0 : c - 3'd1;
            if (c[2] != alt) begin
                if (c[2] == tk) uu = (uu == 2'd3) ? 2'd3 : uu + 2'd1;
                else            uu = (uu == 2'd0) ? 2'd0 : uu - 2'd1;
            end
            o.u[p*2 +: 2] = uu;
        end
        if (mp && !(pv && p == 3)) begin
            for (int j = (pv ? p + 1 : 0); j < 4; j++)
                if (u[j*2 +: 2] == 2'd0) f.push_back(j);
            if (f.size() > 0) begin
                pick = (f.size() > 1 && lf >= 8'd170) ? f[1] : f[0];
                o.en[pick]  = 1'b1;
                o.twe[pick] = 1'b1;
                o.idx[pick*10 +: 10] = idx[pick*10 +: 10];
                o.tag[pick*8 +: 8]   = tag[pick*8 +: 8];
                o.ctr[pick*3 +: 3]   = tk ? 3'd4 : 3'd3;
                o.u[pick*2 +: 2]     = 2'd0;
            end else begin
                o.fail = 1'b1;
                for (int j = (pv ? p + 1 : 0); j < 4; j++) begin
                    o.en[j] = 1'b1;
                    o.idx[j*10 +: 10] = idx[j*10 +: 10];
                    o.ctr[j*3 +: 3]   = ctr[j*3 +: 3];
                    uu = u[j*2 +: 2];
                    o.u[j*2 +: 2] = (uu == 2'd0) ? 2'd0 : uu - 2'd1;
                end
            end
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step(
        input string name, input logic r, v, tk, mp, pv,
        input logic [1:0] pr, input logic alt, input logic [11:0] ctr,
        input logic [7:0] u, input logic [39:0] idx, input logic [31:0] tag);
        out_t e;
        out_t o;
        rst = r; cm_valid = v; cm_taken = tk; cm_mispred = mp;
        cm_prov_valid = pv; cm_provider = pr; cm_alt_pred = alt;
        cm_ctr = ctr; cm_useful = u; cm_index = idx; cm_tag = tag;
        e = model(r, v, tk, mp, pv, pr, alt, ctr, u, idx, tag, m_lfsr);
        if (r) begin
            m_cnt = 0;
            m_phase = 1'b0;
        end else if (v) begin
            if (m_cnt == 7) begin
                e.fhi = !m_phase;
                e.flo = m_phase;
                m_phase = !m_phase;
            end
            m_cnt = (m_cnt + 1) % 8;
        end
        exp_q.push_back(e);
        @(posedge clk);
        m_lfsr = r ? 8'hFF : lfsr_next(m_lfsr);
        #1;
        o = {upd_en, upd_index, upd_ctr, upd_useful, upd_tag,
             upd_tag_we, alloc_fail, flush_ubits_hi, flush_ubits_lo};
        chk({name, "_q"}, 128'(exp_q.size()), 128'd1);
        if (exp_q.size() > 0) chk(name, o, exp_q.pop_front());
    endtask

    initial begin
        step("reset", 1, 0, 0, 0, 0, 2'd0, 0, 12'h0, 8'h0, IDX, TAG);
        chk("rst_en", upd_en, 4'b0);
        chk("rst_lfsr", dut.lfsr, 8'hFF);
        step("reset2", 1, 0, 0, 0, 0, 2'd0, 0, 12'h0, 8'h0, IDX, TAG);

        step("prov_sat", 0, 1, 1, 0, 1, 2'd2, 1,
             {3'd0, 3'd7, 3'd0, 3'd0}, {2'd1, 2'd2, 2'd1, 2'd1}, IDX, TAG);
        chk("t1_en", upd_en, 4'b0100);
        chk("t1_ctr", upd_ctr[8:6], 3'd7);
        chk("t1_u", upd_useful[5:4], 2'd2);
        chk("t1_twe", upd_tag_we, 4'b0);

        step("prov_alloc", 0, 1, 0, 1, 1, 2'd1, 0,
             {3'd0, 3'd0, 3'd4, 3'd0}, {2'd0, 2'd0, 2'd2, 2'd1}, IDX, TAG);
        chk("t2_en1", upd_en[1], 1'b1);
        chk("t2_ctr1", upd_ctr[5:3], 3'd3);
        chk("t2_u1", upd_useful[3:2], 2'd1);
        chk("t2_nalloc", 128'($countones(upd_tag_we & 4'b1100)), 128'd1);

        step("nohit_fail", 0, 1, 1, 1, 0, 2'd0, 0,
             {3'd1, 3'd2, 3'd5, 3'd6}, 8'h55, IDX, TAG);
        chk("t3_en", upd_en, 4'b1111);
        chk("t3_u", upd_useful, 8'h00);
        chk("t3_fail", alloc_fail, 1'b1);
        chk("t3_twe", upd_tag_we, 4'b0);
        chk("t3_ctr", upd_ctr, {3'd1, 3'd2, 3'd5, 3'd6});

        step("prov3", 0, 1, 0, 1, 1, 2'd3, 1,
             {3'd5, 3'd0, 3'd0, 3'd0}, 8'h00, IDX, TAG);
        chk("t4_en", upd_en, 4'b1000);
        chk("t4_fail", alloc_fail, 1'b0);

        step("idle", 0, 0, 1, 1, 0, 2'd0, 0, 12'h0, 8'h0, IDX, TAG);
        chk("idle_en", upd_en, 4'b0);

        step("rst_commit", 1, 1, 1, 1, 0, 2'd0, 0, 12'h0, 8'h0, IDX, TAG);
        chk("rstc_en", upd_en, 4'b0);
        chk("rstc_fail", alloc_fail, 1'b0);

        for (int k = 1; k <= 16; k++) begin
            step("flush", 0, 1, 1, 0, 0, 2'd0, 0, 12'h0, 8'h0, IDX, TAG);
            chk("flush_hi", flush_ubits_hi, 1'(k == 8));
            chk("flush_lo", flush_ubits_lo, 1'(k == 16));
            chk("flush_both", flush_ubits_hi & flush_ubits_lo, 1'b0);
        end

        for (int k = 0; k < 1000; k++) begin
            step("two_free", 0, 1, 1, 1, 0, 2'd0, 0,
                 12'h000, {2'd0, 2'd0, 2'd1, 2'd1}, IDX, TAG);
            low += int'(upd_tag_we[2]);
        end
        chk("alloc_ratio", 1'(low >= 600 && low <= 720), 1'b1);
        chk("lfsr_track", dut.lfsr, m_lfsr);

        for (int k = 0; k < 400; k++) begin
            step("random", 0, 1'($urandom_range(0, 7) != 0), 1'($urandom),
                 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                 12'($urandom), 8'($urandom), 40'({$urandom, $urandom}),
                 32'($urandom));
        end
        chk("lfsr_end", dut.lfsr, m_lfsr);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tage_update_unit.md
Name: tage_update_unit

Overview:
- Write-side companion of the TAGE predictor front end.
- Consumes one committed conditional branch per cycle, together with the prediction metadata captured at fetch.
- Produces registered per-bank write requests: provider counter/useful update, entry allocation on mispredict, and useful decay on allocation failure.
- Generates the periodic useful-bit flush pulses (hi/lo alternating) and owns the 8-bit LFSR used for allocation choice.

Parameters:
- IDX_W, 10, index width per tagged bank
- TAG_W, 8, tag width per entry
- CTR_W, 3, prediction counter width (MSB = taken)
- U_W, 2, useful counter width
- URST_LOG2, 18, log2 of committed branches between useful flushes

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cm_valid  in  1  committed branch valid this cycle
- cm_taken  in  1  actual branch direction
- cm_mispred  in  1  final prediction was wrong
- cm_prov_valid  in  1  some bank hit at prediction
- cm_provider  in  2  hitting bank with longest history
- cm_alt_pred  in  1  alternate prediction direction
- cm_ctr  in  4*CTR_W  counter read from each bank, bank i at [i*CTR_W +: CTR_W]
- cm_useful  in  4*U_W  useful bits read from each bank
- cm_index  in  4*IDX_W  index used per bank
- cm_tag  in  4*TAG_W  computed tag per bank
- upd_en  out  4  per-bank write enable, 1-cycle pulse
- upd_index  out  4*IDX_W  write index per bank
- upd_ctr  out  4*CTR_W  counter to write per bank
- upd_useful  out  4*U_W  useful value to write per bank
- upd_tag  out  4*TAG_W  tag to write per bank
- upd_tag_we  out  4  tag is being (re)written, allocation only
- alloc_fail  out  1  pulse: mispredict found no free entry
- flush_ubits_hi  out  1  pulse: clear useful MSB in all banks
- flush_ubits_lo  out  1  pulse: clear useful LSB in all banks

Behaviour:
- Latency: all outputs registered, valid exactly 1 cycle after cm_valid. One commit accepted per cycle, no backpressure. Outputs are 0 in any cycle following cm_valid=0.
- Reset: all outputs 0; LFSR=8'hFF; commit counter=0; flush phase=0.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, advances every cycle (not during rst).
  - prob = (lfsr < 8'd170), sampled in the cm_valid cycle.
- Provider update, when cm_prov_valid, on bank p=cm_provider:
  - upd_en[p]=1; index = cm_index[p].
  - ctr saturates: +1 if taken (max 7), -1 if not (min 0).
  - If ctr[p][MSB] != cm_alt_pred: useful +1 when ctr[p][MSB]==cm_taken, else -1; saturate at 3/0. Otherwise useful is unchanged (written back as read).
  - upd_tag_we[p]=0.
- Allocation, only when cm_mispred and not (cm_prov_valid and cm_provider==3):
  - Candidate banks: j > cm_provider if cm_prov_valid, else all j. A candidate is free when useful[j]==0.
  - One or more free: pick lowest free c0. If a second free c1 exists and prob==0, pick c1 instead.
  - Allocated bank: upd_en=1, upd_tag_we=1, tag=cm_tag[j], index=cm_index[j], useful=0, ctr = cm_taken ? 3'd4 : 3'd3.
  - None free: every candidate bank gets upd_en=1, upd_tag_we=0, useful-1 (saturate at 0), ctr unchanged; alloc_fail=1.
  - Candidate sets never include the provider, so no bank receives two writes.
- Useful flush:
  - Commit counter (URST_LOG2 bits) increments per cm_valid.
  - On wrap to 0, pulse flush_ubits_hi if phase==0, else flush_ubits_lo, then toggle phase. The pulse is aligned with that commit's upd outputs.
- Reset mid-operation: a commit in the rst cycle is dropped; the next cycle's outputs are 0.

Test Plan:
- Reset, then cm_prov_valid=1, provider=2, ctr[2]=7, taken=1, mispred=0, alt=1 -> next cycle upd_en=4'b0100, upd_ctr[2]=7, useful unchanged, upd_tag_we=0.
- provider=1, ctr[1]=4, alt=0, taken=0, mispred=1, useful[1]=2, useful[3:2]={0,0} -> upd_en=4'b1110; ctr[1]=3, useful[1]=1; allocation into bank 2 or 3 per prob, ctr=3, useful=0, tag_we set.
- No hit, mispred, taken=1, all useful=1 -> upd_en=4'b1111, all useful=0, alloc_fail=1, upd_tag_we=0.
- provider=3, mispred=1 -> only upd_en[3], no allocation, alloc_fail=0.
- URST_LOG2=3, 8 commits -> flush_ubits_hi on the 8th; 16 commits -> flush_ubits_lo on the 16th; never both at once.
- 1000 allocations with two free candidates -> lower bank chosen roughly 2/3 of the time. LFSR sequence after reset starts at 8'hFF and matches the reference model.
